// File: rtl/alu_seq_pkg.sv
// Shared types and helpers for the ALU instruction sequencer.
// Holds the sequencer state enum, default widths and field-slice helpers.
package alu_seq_pkg;

  localparam int DEF_NUM_REGS    = 6;
  localparam int DEF_INSTR_W     = 16;
  localparam int DEF_OP_W        = 4;
  localparam int DEF_FIELD_W     = 6;
  localparam int DEF_ALU_OP_BASE = 9;

  typedef enum logic [3:0] {
    IDLE,
    RD_A,
    LD_A,
    GAP,
    RD_B,
    LD_B,
    LD_IMM,
    EXEC,
    DRIVE,
    WB,
    DONE,
    HOLD
  } state_t;

  // LSB position of the src_a/dst field, which sits directly below the opcode.
  function automatic int src_a_lsb(int instr_w, int op_w, int field_w);
    return instr_w - op_w - field_w;
  endfunction

  // Extract 'width' bits of 'word' starting at bit 'lsb' (zero-extended result).
  function automatic logic [31:0] slice_field(logic [31:0] word, int lsb, int width);
    return (word >> lsb) & ((32'd1 << width) - 32'd1);
  endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Handshake and control bus between the ALU sequencer and its environment.
// The imm_en signal exists only when ALU_SEQ_IMM_EN is defined.
interface alu_seq_ctrl_if #(
  parameter int NUM_REGS = alu_seq_pkg::DEF_NUM_REGS,
  parameter int INSTR_W  = alu_seq_pkg::DEF_INSTR_W
);

  logic                start;
  logic [INSTR_W-1:0]  instruction;
  logic                if_active;
  logic                busy;
  logic                done;
  logic                bad_reg;
  logic                pc_inc;
  logic [NUM_REGS-1:0] rx_out;
  logic [NUM_REGS-1:0] rx_in;
  logic                alu_in0;
  logic                alu_in1;
  logic                alu_out_latch;
  logic                alu_out_en;
`ifdef ALU_SEQ_IMM_EN
  logic                imm_en;
`endif

  // Requester side: issues instructions, observes the control strobes.
  modport master (
    output start, instruction, if_active,
`ifdef ALU_SEQ_IMM_EN
    input  imm_en,
`endif
    input  busy, done, bad_reg, pc_inc, rx_out, rx_in,
    input  alu_in0, alu_in1, alu_out_latch, alu_out_en
  );

  // Sequencer side.
  modport slave (
    input  start, instruction, if_active,
`ifdef ALU_SEQ_IMM_EN
    output imm_en,
`endif
    output busy, done, bad_reg, pc_inc, rx_out, rx_in,
    output alu_in0, alu_in1, alu_out_latch, alu_out_en
  );

endinterface

// File: rtl/reg_onehot_dec.sv
// Register index to one-hot enable decoder.
// Index k lights bit NUM_REGS-1-k; indices past the register file give zero
// and raise out_of_range.
module reg_onehot_dec #(
  parameter int NUM_REGS = 6,
  parameter int FIELD_W  = 6
) (
  input  logic [FIELD_W-1:0]  index,
  output logic [NUM_REGS-1:0] onehot,
  output logic                out_of_range
);

  // One extra bit so NUM_REGS == 2**FIELD_W still compares correctly.
  localparam logic [FIELD_W:0] NUM_REGS_W = (FIELD_W+1)'(NUM_REGS);

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_bit
      assign onehot[NUM_REGS-1-gi] = (index == FIELD_W'(gi));
    end
  endgenerate

  assign out_of_range = ({1'b0, index} >= NUM_REGS_W);

endmodule

// File: rtl/alu_seq_ctrl.sv
// ALU instruction sequencer: captures an ALU-class instruction on start and
// plays out a fixed Moore sequence of register-file / ALU control strobes.
// Instruction fetch activity (if_active) aborts the sequence.
// Optional immediate operand path enabled by defining ALU_SEQ_IMM_EN.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int NUM_REGS    = DEF_NUM_REGS,
  parameter int INSTR_W     = DEF_INSTR_W,
  parameter int OP_W        = DEF_OP_W,
  parameter int FIELD_W     = DEF_FIELD_W,
  parameter int ALU_OP_BASE = DEF_ALU_OP_BASE
) (
  input logic           clk,
  input logic           rst,
  alu_seq_ctrl_if.slave bus
);

  localparam int          A_LSB  = src_a_lsb(INSTR_W, OP_W, FIELD_W);
  localparam logic [31:0] BASE_U = 32'(ALU_OP_BASE);

  state_t              state_reg, state_next;
  logic [FIELD_W-1:0]  a_reg, b_reg;
  logic                flag_reg;

  logic [OP_W-1:0]     opcode;
  logic [FIELD_W-1:0]  a_in, b_in;
  logic                is_alu, accept, imm_sel;
  logic [NUM_REGS-1:0] oh_a, oh_b, oh_d;
  logic                oor_a, oor_b, oor_d;

  assign opcode = bus.instruction[INSTR_W-1 -: OP_W];
  assign a_in   = FIELD_W'(slice_field(32'(bus.instruction), A_LSB, FIELD_W));
  assign b_in   = FIELD_W'(slice_field(32'(bus.instruction), 0, FIELD_W));
  assign is_alu = (32'(opcode) >= BASE_U);
  assign accept = (state_reg == IDLE) && bus.start && is_alu && !bus.if_active;

`ifdef ALU_SEQ_IMM_EN
  assign imm_sel = b_reg[FIELD_W-1];
`else
  assign imm_sel = 1'b0;
`endif

  reg_onehot_dec #(.NUM_REGS(NUM_REGS), .FIELD_W(FIELD_W)) u_dec_src_a (
    .index(a_reg), .onehot(oh_a), .out_of_range(oor_a)
  );
  reg_onehot_dec #(.NUM_REGS(NUM_REGS), .FIELD_W(FIELD_W)) u_dec_src_b (
    .index(b_reg), .onehot(oh_b), .out_of_range(oor_b)
  );
  // dst shares the src_a field but gets its own decoder for the write-back enable.
  reg_onehot_dec #(.NUM_REGS(NUM_REGS), .FIELD_W(FIELD_W)) u_dec_dst (
    .index(a_reg), .onehot(oh_d), .out_of_range(oor_d)
  );

  // State register and operand capture; operands only change on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        a_reg <= a_in;
        b_reg <= b_in;
      end
    end
  end

  // Sticky bad-register flag: cleared on accept, set whenever a decoded index misses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_reg <= 1'b0;
    end else if (accept) begin
      flag_reg <= 1'b0;
    end else if ((((state_reg == RD_A) || (state_reg == LD_A)) && oor_a) ||
                 (((state_reg == RD_B) || (state_reg == LD_B)) && oor_b) ||
                 ((state_reg == WB) && oor_d)) begin
      flag_reg <= 1'b1;
    end
  end

  // Next-state logic; fetch activity wins over everything outside IDLE.
  always_comb begin
    state_next = state_reg;
    if ((state_reg != IDLE) && bus.if_active) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    state_next = accept ? RD_A : IDLE;
        RD_A:    state_next = LD_A;
        LD_A:    state_next = GAP;
        GAP:     state_next = imm_sel ? LD_IMM : RD_B;
        RD_B:    state_next = LD_B;
        LD_B:    state_next = EXEC;
        LD_IMM:  state_next = EXEC;
        EXEC:    state_next = DRIVE;
        DRIVE:   state_next = WB;
        WB:      state_next = DONE;
        DONE:    state_next = HOLD;
        HOLD:    state_next = bus.start ? HOLD : IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Moore output decode from state and captured operands.
  always_comb begin
    bus.busy          = (state_reg != IDLE);
    bus.done          = 1'b0;
    bus.bad_reg       = 1'b0;
    bus.pc_inc        = 1'b0;
    bus.rx_out        = '0;
    bus.rx_in         = '0;
    bus.alu_in0       = 1'b0;
    bus.alu_in1       = 1'b0;
    bus.alu_out_latch = 1'b0;
    bus.alu_out_en    = 1'b0;
`ifdef ALU_SEQ_IMM_EN
    bus.imm_en        = 1'b0;
`endif
    case (state_reg)
      RD_A: begin
        bus.rx_out = oh_a;
        bus.pc_inc = 1'b1;
      end
      LD_A: begin
        bus.rx_out  = oh_a;
        bus.alu_in0 = 1'b1;
      end
      RD_B: bus.rx_out = oh_b;
      LD_B: begin
        bus.rx_out  = oh_b;
        bus.alu_in1 = 1'b1;
      end
      LD_IMM: begin
        bus.alu_in1 = 1'b1;
`ifdef ALU_SEQ_IMM_EN
        bus.imm_en  = 1'b1;
`endif
      end
      EXEC:  bus.alu_out_latch = 1'b1;
      DRIVE: bus.alu_out_en    = 1'b1;
      WB: begin
        bus.alu_out_en = 1'b1;
        bus.rx_in      = oh_d;
      end
      DONE: begin
        bus.done    = 1'b1;
        bus.bad_reg = flag_reg;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl (NUM_REGS=6, 16-bit instructions).
// Expected per-cycle strobes come from a table-style model of the sequence.
// Covers the ALU_SEQ_IMM_EN build as well when that macro is defined.
module tb_alu_seq_ctrl;

  localparam int NR = 6;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       bad;
    logic       pc;
    logic       in0;
    logic       in1;
    logic       lat;
    logic       en;
    logic       imm;
    logic [5:0] ro;
    logic [5:0] ri;
  } out_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  out_t exp_q[$];
  out_t zero_o;

  alu_seq_ctrl_if #(.NUM_REGS(NR), .INSTR_W(16)) bus ();

  alu_seq_ctrl #(
    .NUM_REGS(NR), .INSTR_W(16), .OP_W(4), .FIELD_W(6), .ALU_OP_BASE(9)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] oh(int idx);
    return (idx < NR) ? 6'(1 << (NR - 1 - idx)) : 6'd0;
  endfunction

  function automatic out_t sample();
    out_t s;
    s      = '0;
    s.busy = bus.busy;
    s.done = bus.done;
    s.bad  = bus.bad_reg;
    s.pc   = bus.pc_inc;
    s.in0  = bus.alu_in0;
    s.in1  = bus.alu_in1;
    s.lat  = bus.alu_out_latch;
    s.en   = bus.alu_out_en;
    s.ro   = bus.rx_out;
    s.ri   = bus.rx_in;
`ifdef ALU_SEQ_IMM_EN
    s.imm  = bus.imm_en;
`endif
    return s;
  endfunction

  // Expected strobes for cycles 1..N after accept, ending with one HOLD cycle.
  function automatic void build_expected(logic [15:0] instr);
    int   a, b;
    bit   imm, bad;
    out_t r;
    a = int'(instr[11:6]);
    b = int'(instr[5:0]);
`ifdef ALU_SEQ_IMM_EN
    imm = instr[5];
`else
    imm = 1'b0;
`endif
    bad = (a >= NR) || (!imm && (b >= NR));
    exp_q.delete();
    r = '0; r.busy = 1; r.pc = 1;  r.ro = oh(a); exp_q.push_back(r);
    r = '0; r.busy = 1; r.in0 = 1; r.ro = oh(a); exp_q.push_back(r);
    r = '0; r.busy = 1;                          exp_q.push_back(r);
    if (imm) begin
      r = '0; r.busy = 1; r.imm = 1; r.in1 = 1;  exp_q.push_back(r);
    end else begin
      r = '0; r.busy = 1; r.ro = oh(b);            exp_q.push_back(r);
      r = '0; r.busy = 1; r.ro = oh(b); r.in1 = 1; exp_q.push_back(r);
    end
    r = '0; r.busy = 1; r.lat = 1;               exp_q.push_back(r);
    r = '0; r.busy = 1; r.en = 1;                exp_q.push_back(r);
    r = '0; r.busy = 1; r.en = 1; r.ri = oh(a);  exp_q.push_back(r);
    r = '0; r.busy = 1; r.done = 1; r.bad = bad; exp_q.push_back(r);
    r = '0; r.busy = 1;                          exp_q.push_back(r);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    out_t s;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.instruction = '0;
    bus.if_active = 1'b0;
    repeat (2) tick();
    s = sample();
    n_checks++;
    if (s !== zero_o) begin
      n_fail++;
      $display("FAIL reset_hold got=%h want=%h", s, zero_o);
    end
    rst = 1'b0;
    tick();
    s = sample();
    n_checks++;
    if (s !== zero_o) begin
      n_fail++;
      $display("FAIL reset_release got=%h want=%h", s, zero_o);
    end
  endtask

  task automatic test_normal();
    out_t s;
    bus.instruction = 16'h9042;
    bus.start = 1'b1;
    build_expected(16'h9042);
    for (int c = 1; c <= exp_q.size(); c++) begin
      tick();
      s = sample();
      n_checks++;
      if (s !== exp_q[c-1]) begin
        n_fail++;
        $display("FAIL normal_cyc%0d got=%h want=%h", c, s, exp_q[c-1]);
      end
    end
    for (int h = 0; h < 2; h++) begin
      tick();
      s = sample();
      n_checks++;
      if (s !== exp_q[exp_q.size()-1]) begin
        n_fail++;
        $display("FAIL normal_hold%0d got=%h want=%h", h, s, exp_q[exp_q.size()-1]);
      end
    end
    bus.start = 1'b0;
    tick();
    s = sample();
    n_checks++;
    if (s !== zero_o) begin
      n_fail++;
      $display("FAIL normal_idle got=%h want=%h", s, zero_o);
    end
    $display("normal: instr=9042 done");
  endtask

  task automatic test_non_alu();
    out_t s;
    bus.instruction = 16'h3042;
    bus.start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      s = sample();
      n_checks++;
      if (s !== zero_o) begin
        n_fail++;
        $display("FAIL non_alu_cyc%0d got=%h want=%h", c, s, zero_o);
      end
    end
    bus.start = 1'b0;
    tick();
    $display("non_alu: instr=3042 ignored");
  endtask

  task automatic test_bad_reg();
    out_t s;
    logic [15:0] seq [2];
    seq[0] = 16'h9047;
    seq[1] = 16'h9042;
    for (int i = 0; i < 2; i++) begin
      bus.instruction = seq[i];
      bus.start = 1'b1;
      build_expected(seq[i]);
      for (int c = 1; c <= exp_q.size(); c++) begin
        tick();
        s = sample();
        n_checks++;
        if (s !== exp_q[c-1]) begin
          n_fail++;
          $display("FAIL bad_reg_i%0d_cyc%0d got=%h want=%h", i, c, s, exp_q[c-1]);
        end
      end
      bus.start = 1'b0;
      tick();
      $display("bad_reg: instr=%h bad_reg expected=%0b", seq[i], exp_q[exp_q.size()-2].bad);
    end
  endtask

  task automatic test_abort();
    out_t s;
    bus.instruction = 16'h9042;
    bus.start = 1'b1;
    build_expected(16'h9042);
    for (int c = 1; c <= 5; c++) begin
      tick();
      s = sample();
      n_checks++;
      if (s !== exp_q[c-1]) begin
        n_fail++;
        $display("FAIL abort_pre_cyc%0d got=%h want=%h", c, s, exp_q[c-1]);
      end
    end
    bus.if_active = 1'b1;   // sampled while in LD_B
    for (int c = 1; c <= 2; c++) begin
      tick();
      s = sample();
      n_checks++;
      if (s !== zero_o) begin
        n_fail++;
        $display("FAIL abort_idle%0d got=%h want=%h", c, s, zero_o);
      end
    end
    bus.if_active = 1'b0;   // start still high: accept on the next edge
    for (int c = 1; c <= exp_q.size(); c++) begin
      tick();
      s = sample();
      n_checks++;
      if (s !== exp_q[c-1]) begin
        n_fail++;
        $display("FAIL abort_restart_cyc%0d got=%h want=%h", c, s, exp_q[c-1]);
      end
    end
    bus.start = 1'b0;
    tick();
    $display("abort: LD_B abort then restart done");
  endtask

  task automatic test_reset_mid();
    out_t s;
    bus.instruction = 16'h9042;
    bus.start = 1'b1;
    build_expected(16'h9042);
    repeat (6) tick();
    s = sample();
    n_checks++;
    if (s !== exp_q[5]) begin
      n_fail++;
      $display("FAIL rstmid_exec got=%h want=%h", s, exp_q[5]);
    end
    #2;
    rst = 1'b1;
    #1;
    s = sample();
    n_checks++;
    if (s !== zero_o) begin
      n_fail++;
      $display("FAIL rstmid_async got=%h want=%h", s, zero_o);
    end
    bus.start = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    s = sample();
    n_checks++;
    if (s !== zero_o) begin
      n_fail++;
      $display("FAIL rstmid_release got=%h want=%h", s, zero_o);
    end
    $display("reset_mid: reset during EXEC");
  endtask

`ifdef ALU_SEQ_IMM_EN
  task automatic test_imm();
    out_t s;
    bus.instruction = 16'h9060;
    bus.start = 1'b1;
    build_expected(16'h9060);
    for (int c = 1; c <= exp_q.size(); c++) begin
      tick();
      s = sample();
      n_checks++;
      if (s !== exp_q[c-1]) begin
        n_fail++;
        $display("FAIL imm_cyc%0d got=%h want=%h", c, s, exp_q[c-1]);
      end
      if (c == 8) begin
        n_checks++;
        if (s.done !== 1'b1) begin
          n_fail++;
          $display("FAIL imm_done_cycle8 got=%0b want=1", s.done);
        end
      end
    end
    bus.start = 1'b0;
    tick();
    $display("imm: instr=9060 done");
  endtask
`endif

  task automatic test_random();
    out_t        s;
    logic [15:0] instr;
    logic [3:0]  op;
    logic [5:0]  a, b;
    bit          blk, aborted;
    int          abort_at, hold, n;
    for (int it = 0; it < 60; it++) begin
      op = 4'($urandom_range(0, 15));
      a  = 6'($urandom_range(0, 7));
      b  = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(32, 63)) : 6'($urandom_range(0, 7));
      instr    = {op, a, b};
      blk      = ($urandom_range(0, 5) == 0);
      abort_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 9)) : 0;
      hold     = int'($urandom_range(0, 2));
      aborted  = 1'b0;
      bus.instruction = instr;
      bus.if_active   = blk;
      bus.start       = 1'b1;
      if ((op < 4'd9) || blk) begin
        tick();
        s = sample();
        n_checks++;
        if (s !== zero_o) begin
          n_fail++;
          $display("FAIL rand%0d_noaccept got=%h want=%h", it, s, zero_o);
        end
        bus.start = 1'b0;
        bus.if_active = 1'b0;
        $display("rand%0d: instr=%h not accepted", it, instr);
        continue;
      end
      build_expected(instr);
      n = exp_q.size() - 1;
      for (int c = 1; c <= n && !aborted; c++) begin
        tick();
        bus.instruction = 16'($urandom);
        s = sample();
        n_checks++;
        if (s !== exp_q[c-1]) begin
          n_fail++;
          $display("FAIL rand%0d_cyc%0d got=%h want=%h", it, c, s, exp_q[c-1]);
        end
        if (c == abort_at) begin
          bus.if_active = 1'b1;
          tick();
          s = sample();
          n_checks++;
          if (s !== zero_o) begin
            n_fail++;
            $display("FAIL rand%0d_abort got=%h want=%h", it, s, zero_o);
          end
          bus.if_active = 1'b0;
          bus.start = 1'b0;
          aborted = 1'b1;
        end
      end
      if (!aborted) begin
        for (int h = 0; h <= hold; h++) begin
          tick();
          s = sample();
          n_checks++;
          if (s !== exp_q[n]) begin
            n_fail++;
            $display("FAIL rand%0d_hold%0d got=%h want=%h", it, h, s, exp_q[n]);
          end
        end
        bus.start = 1'b0;
        tick();
        s = sample();
        n_checks++;
        if (s !== zero_o) begin
          n_fail++;
          $display("FAIL rand%0d_release got=%h want=%h", it, s, zero_o);
        end
      end
      $display("rand%0d: instr=%h abort_at=%0d hold=%0d", it, instr, abort_at, hold);
    end
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    n_checks = 0;
    n_fail = 0;
    zero_o = '0;
    test_reset();
    test_normal();
    test_non_alu();
    test_bad_reg();
    test_abort();
    test_reset_mid();
`ifdef ALU_SEQ_IMM_EN
    test_imm();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Parametrised ALU instruction sequencer for the microcontroller datapath.
- Captures an ALU-class instruction on a start/done handshake.
- Drives the register-file output and input one-hot enables, the ALU operand latches, the ALU result latch/enable and the PC increment, as a fixed Moore sequence.
- Sits beside the instruction-fetch FSM. Fetch activity (if_active) aborts it.

Parameters:
- NUM_REGS, 6: number of general registers; width of the one-hot enable buses (max 2^FIELD_W).
- INSTR_W, 16: instruction width.
- OP_W, 4: opcode width, taken from instruction MSBs.
- FIELD_W, 6: width of each operand field.
  - src_a/dst = instr[INSTR_W-OP_W-1 -: FIELD_W]
  - src_b = instr[FIELD_W-1:0]
- ALU_OP_BASE, 9: opcodes >= ALU_OP_BASE are ALU instructions.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request to execute the instruction presented on instruction.
- instruction  in  INSTR_W  instruction word; sampled only when start is accepted.
- if_active  in  1  fetch in progress; synchronous abort.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- bad_reg  out  1  valid with done; any referenced register index >= NUM_REGS.
- pc_inc  out  1  PC increment strobe.
- rx_out  out  NUM_REGS  one-hot register output enable.
- rx_in  out  NUM_REGS  one-hot register load enable.
- alu_in0  out  1  latch bus into ALU operand A.
- alu_in1  out  1  latch bus into ALU operand B.
- alu_out_latch  out  1  latch ALU result.
- alu_out_en  out  1  drive ALU result onto bus.

Behaviour:
- Clocking/reset:
  - Single clock domain: clk, with asynchronous active-high reset rst.
  - rst forces state=IDLE and clears the captured instruction register.
- Outputs:
  - All outputs are Moore-decoded from state and the captured instruction.
  - Every output is 0 during and after reset.
- One-hot decode:
  - Index k drives bit NUM_REGS-1-k.
  - Index >= NUM_REGS drives all zeros and sets the internal sticky bad flag. The flag is cleared on accept.
- Accept: in IDLE, start=1, opcode >= ALU_OP_BASE and if_active=0.
  - The instruction is captured on that edge; the next state is RD_A.
  - A non-ALU opcode with start=1 is ignored; the block stays in IDLE with no outputs.
- State sequence (each 1 cycle; unlisted outputs 0):
  - RD_A: rx_out=onehot(src_a), pc_inc=1.
  - LD_A: rx_out=onehot(src_a), alu_in0=1.
  - GAP: all outputs 0 (bus turnaround).
  - RD_B: rx_out=onehot(src_b).
  - LD_B: rx_out=onehot(src_b), alu_in1=1.
  - EXEC: alu_out_latch=1.
  - DRIVE: alu_out_en=1.
  - WB: alu_out_en=1, rx_in=onehot(dst).
  - DONE: done=1, bad_reg=flag.
  - HOLD: all outputs 0, busy=1. Stays in HOLD while start=1; goes to IDLE when start=0.
- Latency: done is high in the 9th cycle after the accepting edge.
  - A new accept is possible no earlier than 1 cycle after start drops.
- Abort: if_active=1 in any non-IDLE state forces IDLE on the next edge.
  - No done pulse is produced.
  - Outputs return to 0 one cycle after abort is sampled.
  - If_active has priority over accept.
- Instruction changes after accept have no effect.
- pc_inc is asserted exactly once per accepted instruction. It is not asserted on an aborted sequence if the abort lands before RD_A is entered.
- Default/illegal state encoding returns to IDLE.

Optional Feature:
- Macro ALU_SEQ_IMM_EN.
- Defined:
  - Adds output imm_en (1 bit).
  - If src_b MSB (instr[FIELD_W-1]) = 1, states RD_B and LD_B are replaced by a single state LD_IMM with imm_en=1 and alu_in1=1.
  - src_b is then not range-checked.
  - done is high in the 8th cycle after accept.
- Undefined:
  - No imm_en port.
  - src_b is always a register index (MSB set means an out-of-range index, so bad_reg=1).

Decomposition:
- Shared package alu_seq_pkg:
  - state enum (IDLE, RD_A, LD_A, GAP, RD_B, LD_B, LD_IMM, EXEC, DRIVE, WB, DONE, HOLD).
  - default width constants.
  - field-slice helper functions.
- One sub-module: reg_onehot_dec (index, NUM_REGS) -> one-hot vector plus out_of_range.
  - Instantiated 3x: src_a, src_b, dst.

Test Plan:
1. Reset mid-sequence:
   - Drive rst high during EXEC -> all outputs 0 immediately; state is IDLE; busy=0 after release.
2. Normal ADD, NUM_REGS=6:
   - instruction=16'h9042 (src_a=1, src_b=2), start held -> RD_A rx_out=6'b010000 with pc_inc=1.
   - LD_B rx_out=6'b001000 with alu_in1=1.
   - WB rx_in=6'b010000.
   - done=1 on cycle 9, bad_reg=0.
   - HOLD until start=0.
3. Non-ALU opcode:
   - instruction=16'h3042, start=1 for 5 cycles -> busy=0 and all outputs 0 throughout.
4. Bad register:
   - src_b=7 -> rx_out=0 in RD_B/LD_B; done=1 with bad_reg=1.
   - The next valid instruction gives bad_reg=0.
5. Abort:
   - Assert if_active during LD_B -> next cycle IDLE, outputs 0, no done pulse.
   - A new start is accepted afterwards.
6. ALU_SEQ_IMM_EN defined:
   - instruction=16'h9060 (src_b MSB=1) -> LD_IMM with imm_en=1 and alu_in1=1.
   - No RD_B state; done on cycle 8.
